// File: rtl/aes_package.sv
// Shared types, constants and helpers for the AES round sequencer.
package aes_package;

    localparam logic [7:0] AES_RCON_INIT = 8'h01;
    localparam logic [7:0] AES_RCON_POLY = 8'h1B;

    typedef enum logic [2:0] {
        AES_IDLE  = 3'd0,
        AES_LOAD  = 3'd1,
        AES_INIT  = 3'd2,
        AES_ROUND = 3'd3,
        AES_FINAL = 3'd4,
        AES_DRAIN = 3'd5,
        AES_DONE  = 3'd6
    } aes_round_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loaded with 01 at init, doubled in GF(2^8) on each step.
module aes_rcon_gen
    import aes_package::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       init,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcon_q <= 8'h00;
        end else if (clear) begin
            rcon_q <= 8'h00;
        end else if (init) begin
            rcon_q <= AES_RCON_INIT;
        end else if (step) begin
            rcon_q <= aes_xtime(rcon_q);
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath: load 4 words, run the rounds,
// drain 4 words. Both streams use valid/ready: a word moves on a cycle where valid & ready.
module aes_round_ctrl
    import aes_package::*;
#(
    parameter int NB_ROUNDS = 10,
    parameter int NB_WORDS  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       start_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [1:0] word_sel_o,
    output logic       dp_load_o,
    output logic       key_load_o,
    output logic       dp_first_o,
    output logic       dp_round_en_o,
    output logic       dp_final_o,
    output logic       key_step_o,
    output logic [7:0] rcon_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'(AES_IDLE);
    localparam logic [2:0] S_LOAD  = 3'(AES_LOAD);
    localparam logic [2:0] S_INIT  = 3'(AES_INIT);
    localparam logic [2:0] S_ROUND = 3'(AES_ROUND);
    localparam logic [2:0] S_FINAL = 3'(AES_FINAL);
    localparam logic [2:0] S_DRAIN = 3'(AES_DRAIN);
    localparam logic [2:0] S_DONE  = 3'(AES_DONE);

    localparam logic [1:0] LAST_WORD   = 2'(NB_WORDS - 1);
    localparam logic [3:0] PENULT_ROUND = 4'(NB_ROUNDS - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] word_q;
    logic [3:0] round_q;
    logic [7:0] rcon_q;
    logic       in_hs, out_hs;
    logic       in_round, in_final;

    assign in_round = (state_q == S_ROUND);
    assign in_final = (state_q == S_FINAL);
    assign in_hs    = (state_q == S_LOAD) & in_valid_i;
    assign out_hs   = (state_q == S_DRAIN) & out_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  if (in_hs && word_q == LAST_WORD) state_d = S_INIT;
            S_INIT:  state_d = (NB_ROUNDS == 1) ? S_FINAL : S_ROUND;
            S_ROUND: if (round_q == PENULT_ROUND) state_d = S_FINAL;
            S_FINAL: state_d = S_DRAIN;
            S_DRAIN: if (out_hs && word_q == LAST_WORD) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            word_q  <= 2'd0;
            round_q <= 4'd0;
        end else if (clear) begin
            state_q <= S_IDLE;
            word_q  <= 2'd0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    word_q  <= 2'd0;
                    round_q <= 4'd0;
                end
                S_LOAD:  if (in_hs) word_q <= word_q + 2'd1;
                S_INIT:  round_q <= 4'd1;
                S_ROUND: round_q <= round_q + 4'd1;
                S_FINAL: begin
                    round_q <= 4'd0;
                    word_q  <= 2'd0;
                end
                S_DRAIN: if (out_hs) word_q <= word_q + 2'd1;
                default: ;
            endcase
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .init    (state_q == S_INIT),
        .step    (in_round),
        .rcon    (rcon_q)
    );

    // Every output is a pure decode of state, so reset and clear zero them all.
    always_comb begin
        in_ready_o    = (state_q == S_LOAD);
        out_valid_o   = (state_q == S_DRAIN);
        word_sel_o    = ((state_q == S_LOAD) || (state_q == S_DRAIN)) ? word_q : 2'd0;
        dp_load_o     = in_hs;
        key_load_o    = (state_q == S_INIT);
        dp_first_o    = (state_q == S_INIT);
        dp_round_en_o = in_round | in_final;
        dp_final_o    = in_final;
        key_step_o    = in_round | in_final;
        rcon_o        = (in_round | in_final) ? rcon_q : 8'h00;
        round_o       = (in_round | in_final) ? round_q : 4'd0;
        busy_o        = (state_q != S_IDLE);
        done_o        = (state_q == S_DONE);
    end

    assign dbg_state_o = state_q;

endmodule
